// File: rtl/hier_child_arbiter.sv
// hier_child_arbiter: round-robin merge of NUM_CHILDREN valid/ready child
// channels into one registered output stage tagged with the winning index.
// Optional build macro HIER_ARB_STATS_EN adds per-child saturating grant
// counters with a select/clear read port.
module hier_child_arbiter #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 8,
    localparam int ID_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [ID_W-1:0]                out_id,
    output logic                           busy
`ifdef HIER_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]                stat_sel,
    input  logic                           stat_clr,
    output logic [15:0]                    stat_count
`endif
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;

    logic              can_accept;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              xfer;

    // The output slot can take a new word when empty or draining this cycle.
    assign can_accept = !out_valid_q || out_ready;
    assign xfer       = can_accept && grant_found && !rst;

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_CHILDREN.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_v;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_v       = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CHILDREN) begin
                idx = idx - NUM_CHILDREN;
            end
            idx_v = ID_W'(idx);
            if (!grant_found && child_valid[idx_v]) begin
                grant_found = 1'b1;
                grant_idx   = idx_v;
            end
        end
    end

    // One-hot grant; held at zero while in reset or when the slot is full.
    always_comb begin
        child_ready = '0;
        if (xfer) begin
            child_ready[grant_idx] = 1'b1;
        end
    end

    // Next state of the output slot and the priority pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = child_data[grant_idx*DATA_W +: DATA_W];
            out_id_d    = grant_idx;
            rr_ptr_d    = (int'(grant_idx) == NUM_CHILDREN - 1) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            // Drained with nothing to refill; payload and id keep last value.
            out_valid_d = 1'b0;
        end
    end

    // Output register slice and pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = out_valid_q | (|child_valid);

`ifdef HIER_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_CHILDREN];

    // Per-child grant counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (rst || stat_clr) begin
                grant_cnt_q[i] <= '0;
            end else if (xfer && (int'(grant_idx) == i) && (grant_cnt_q[i] != 16'hFFFF)) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter read mux; selects beyond the last child read as zero.
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (int'(stat_sel) == i) begin
                stat_count = grant_cnt_q[i];
            end
        end
    end
`endif

endmodule
